fourbit_4to1mux: RTL and testbench

FOURBIT_4TO1MUX -- requirements
Module: fourbit_4to1mux

---
 rtl/fourbit_4to1mux.sv | 59 +++++
 tb/tb_fourbit_4to1mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fourbit_4to1mux.sv
// rtl/fourbit_4to1mux.sv - 4:1 word mux with registered copy, captured select and change flag
// Optional feature macro: FOURBIT_4TO1MUX_ONEHOT_EN adds sel_oh, the one-hot decode of sel.
module fourbit_4to1mux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic             y_chg
`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
  ,
  output logic [3:0]       sel_oh
`endif
);

  // Zero-latency select; all four codes map to a data word, so no default arm is needed.
  always_comb begin
    y = i0;
    unique case (sel)
      2'b00: y = i0;
      2'b01: y = i1;
      2'b10: y = i2;
      2'b11: y = i3;
    endcase
  end

  // Registered copy: reset wins over en, a hold clears the change flag, and a load
  // flags only a real change of the stored word (a new sel alone does not count).
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= 2'b00;
      y_chg <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= sel;
      y_chg <= (y != y_q);
    end else begin
      y_chg <= 1'b0;
    end
  end

`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
  // One-hot view of the current select, bit n set when sel == n.
  always_comb begin
    sel_oh = 4'b0000;
    sel_oh[sel] = 1'b1;
  end
`endif

endmodule

// File: tb/tb_fourbit_4to1mux.sv
// tb/tb_fourbit_4to1mux.sv - directed scoreboard bench for fourbit_4to1mux
module tb_fourbit_4to1mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] i3 = 4'h0, i2 = 4'h0, i1 = 4'h0, i0 = 4'h0;
  logic       en = 1'b0;
  logic [3:0] y, y_q;
  logic [1:0] sel_q;
  logic       y_chg;
`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
  logic [3:0] sel_oh;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] yq;
    logic [1:0] sq;
    logic       chg;
  } exp_t;

  exp_t sb[$];

  // reference register state
  logic [3:0] m_yq;
  logic [1:0] m_sq;
  logic       m_chg;

  fourbit_4to1mux #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .i3(i3), .i2(i2), .i1(i1), .i0(i0),
    .en(en), .y(y), .y_q(y_q), .sel_q(sel_q), .y_chg(y_chg)
`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
    , .sel_oh(sel_oh)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mux_ref(input logic [1:0] s, input logic [3:0] a3,
                                         input logic [3:0] a2, input logic [3:0] a1,
                                         input logic [3:0] a0);
    case (s)
      2'd0: return a0;
      2'd1: return a1;
      2'd2: return a2;
      default: return a3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive inputs mid-cycle, check y combinationally, queue the expected register state
  task automatic drive(input logic r, input logic e, input logic [1:0] s,
                       input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    logic [3:0] ny;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sel = s; i3 = a3; i2 = a2; i1 = a1; i0 = a0;
    #1;
    ny = mux_ref(s, a3, a2, a1, a0);
    check("y_comb", {4'h0, y}, {4'h0, ny});
    if (r) begin
      m_yq = 4'h0; m_sq = 2'b00; m_chg = 1'b0;
    end else if (e) begin
      m_chg = (ny != m_yq); m_yq = ny; m_sq = s;
    end else begin
      m_chg = 1'b0;
    end
    x.yq = m_yq; x.sq = m_sq; x.chg = m_chg;
    sb.push_back(x);
  endtask

  // clock edge, then pop and compare the registered outputs
  task automatic edge_check(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      x = sb.pop_front();
      check({tag, "_y_q"},   {4'h0, y_q},   {4'h0, x.yq});
      check({tag, "_sel_q"}, {6'h0, sel_q}, {6'h0, x.sq});
      check({tag, "_y_chg"}, {7'h0, y_chg}, {7'h0, x.chg});
    end
  endtask

  initial begin
    m_yq = 4'h0; m_sq = 2'b00; m_chg = 1'b0;

    // combinational sweep before any edge
    i3 = 4'b1000; i2 = 4'b0100; i1 = 4'b0010; i0 = 4'b0001;
    sel = 2'b00; #1 check("sweep_s0", {4'h0, y}, 8'h01);
    sel = 2'b01; #1 check("sweep_s1", {4'h0, y}, 8'h02);
    sel = 2'b10; #1 check("sweep_s2", {4'h0, y}, 8'h04);
`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
    check("oh_s2", {4'h0, sel_oh}, 8'h04);
`endif
    sel = 2'b11; #1 check("sweep_s3", {4'h0, y}, 8'h08);
    i3 = 4'b1110; i2 = 4'b1110; i1 = 4'b1110; i0 = 4'b1110;
    sel = 2'b00; #1 check("all_1110", {4'h0, y}, 8'h0e);
`ifdef FOURBIT_4TO1MUX_ONEHOT_EN
    check("oh_s0", {4'h0, sel_oh}, 8'h01);
`endif

    // reset, y keeps tracking during reset
    drive(1'b1, 1'b0, 2'b10, 4'h3, 4'h9, 4'h5, 4'h7);
    edge_check("reset");
    check("reset_abs_y_q", {4'h0, y_q}, 8'h00);

    // first load compares against zero
    drive(1'b0, 1'b1, 2'b11, 4'b1010, 4'h0, 4'h0, 4'h0);
    edge_check("load1");
    check("load1_abs", {y_q, 2'b00, sel_q}, 8'ha3);

    // hold: y follows new inputs, register stays
    drive(1'b0, 1'b0, 2'b01, 4'b1010, 4'h0, 4'b0101, 4'h0);
    check("hold_y", {4'h0, y}, 8'h05);
    edge_check("hold");

    // same word reloaded via a different sel: no change flag
    drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h6, 4'h6, 4'h0);
    edge_check("load6");
    drive(1'b0, 1'b1, 2'b10, 4'h0, 4'h6, 4'h6, 4'h0);
    edge_check("same_val");

    // reset priority over en with y=1111
    drive(1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'hf);
    edge_check("rst_pri");

    // first load after reset of a zero word: no change
    drive(1'b0, 1'b1, 2'b00, 4'h1, 4'h1, 4'h1, 4'h0);
    edge_check("zero_load");

    // mixed random loads and holds
    for (int k = 0; k < 40; k++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      edge_check("rand");
    end

    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
